// File: rtl/mem_guard.sv
// mem_guard: access-control monitor for the trusted code base and N data regions.
// Optional atomicity checks (illegal entry/exit, irq in TCB) enabled by MEM_GUARD_ATOMIC_EN.
module mem_guard #(
    parameter int                      N_REGIONS     = 5,
    parameter logic [16*N_REGIONS-1:0] REGION_BASE   = {16'hFEFE, 16'hFFDF, 16'h9000,
                                                        16'h8000, 16'hA000},
    parameter logic [16*N_REGIONS-1:0] REGION_SIZE   = {16'h001F, 16'h0033, 16'h001F,
                                                        16'h001F, 16'h1000},
    parameter logic [3*N_REGIONS-1:0]  REGION_POLICY = {3'b011, 3'b110, 3'b110,
                                                        3'b100, 3'b111},
    parameter logic [15:0]             TCB_BASE      = 16'hE000,
    parameter logic [15:0]             TCB_SIZE      = 16'h1000,
    parameter logic [15:0]             RESET_VECTOR  = 16'hFFFE,
    parameter int                      MIN_HOLD      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic        r_en,
    input  logic        w_en,
    input  logic        irq,
    output logic        reset,
    output logic [2:0]  viol_cause,
    output logic [2:0]  viol_region,
    output logic [7:0]  viol_count
);

    localparam logic [16:0] TCB_END   = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE} - 17'd2;
    localparam logic [15:0] TCB_LAST  = TCB_END[15:0];
    localparam logic [7:0]  HOLD_INIT = 8'(MIN_HOLD - 1);

    typedef enum logic {RUN, KILL} state_t;

    state_t               state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic [2:0]           cause_d, region_d;
    logic [7:0]           count_d;
    logic [N_REGIONS-1:0] rd_hit, wr_hit, twr_hit;
    logic [2:0]           vcause, vregion;
    logic                 pc_tr;

    function automatic logic is_trusted(input logic [15:0] a);
        return (a >= TCB_BASE) && ({1'b0, a} <= TCB_END);
    endfunction

    // 17-bit bound so a region touching 16'hFFFF does not wrap
    function automatic logic in_region(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        logic [16:0] last;
        last = {1'b0, base} + {1'b0, size} - 17'd1;
        return (size != 16'd0) && (a >= base) && ({1'b0, a} <= last);
    endfunction

    function automatic logic [2:0] first_idx(input logic [N_REGIONS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign pc_tr = is_trusted(pc);

    always_comb begin
        rd_hit  = '0;
        wr_hit  = '0;
        twr_hit = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (in_region(data_addr, REGION_BASE[16*i +: 16], REGION_SIZE[16*i +: 16])) begin
                rd_hit[i]  = REGION_POLICY[3*i];
                wr_hit[i]  = REGION_POLICY[3*i+1];
                twr_hit[i] = REGION_POLICY[3*i+2];
            end
        end
    end

`ifdef MEM_GUARD_ATOMIC_EN
    logic [15:0] prev_pc;
    logic        prev_tr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_pc <= RESET_VECTOR;
        else          prev_pc <= pc;
    end

    assign prev_tr = is_trusted(prev_pc);
`else
    logic unused_irq;
    assign unused_irq = irq;
`endif

    // Later assignments override earlier ones: lowest cause code wins
    always_comb begin
        vcause  = 3'd0;
        vregion = 3'd0;
`ifdef MEM_GUARD_ATOMIC_EN
        if (irq && pc_tr) vcause = 3'd6;
        if (prev_tr && !pc_tr && prev_pc != TCB_LAST) vcause = 3'd5;
        if (pc_tr && !prev_tr && pc != TCB_BASE) vcause = 3'd4;
`endif
        if (pc_tr && w_en && twr_hit == '0) vcause = 3'd3;
        if (!pc_tr && w_en && |wr_hit) begin
            vcause  = 3'd2;
            vregion = first_idx(wr_hit);
        end
        if (!pc_tr && r_en && |rd_hit) begin
            vcause  = 3'd1;
            vregion = first_idx(rd_hit);
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cause_d  = viol_cause;
        region_d = viol_region;
        count_d  = viol_count;
        unique case (state_q)
            RUN: begin
                if (vcause != 3'd0) begin
                    state_d  = KILL;
                    hold_d   = HOLD_INIT;
                    cause_d  = vcause;
                    region_d = vregion;
                    if (viol_count != 8'hFF) count_d = viol_count + 8'd1;
                end
            end
            KILL: begin
                if (hold_q == 8'd0 && pc == RESET_VECTOR && vcause == 3'd0) begin
                    state_d = RUN;
                end else if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            hold_q      <= 8'd0;
            viol_cause  <= 3'd0;
            viol_region <= 3'd0;
            viol_count  <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            viol_cause  <= cause_d;
            viol_region <= region_d;
            viol_count  <= count_d;
        end
    end

    assign reset = (state_q == KILL);

endmodule

// File: tb/tb_mem_guard.sv
// tb_mem_guard: random and directed stimulus against a behavioural model of mem_guard.
// Atomicity checks are exercised when MEM_GUARD_ATOMIC_EN is defined.
module tb_mem_guard;

    localparam int RV   = 'hFFFE;
    localparam int TB   = 'hE000;
    localparam int TS   = 'h1000;
    localparam int HOLD = 4;

    int rb[5] = '{'hA000, 'h8000, 'h9000, 'hFFDF, 'hFEFE};
    int rs[5] = '{'h1000, 'h001F, 'h001F, 'h0033, 'h001F};
    int rp[5] = '{7, 4, 6, 6, 3};

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pc = 16'hFFFE;
    logic [15:0] data_addr = 16'h0000;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic        irq = 1'b0;
    logic        reset;
    logic [2:0]  viol_cause;
    logic [2:0]  viol_region;
    logic [7:0]  viol_count;

    int errs = 0;
    int checks = 0;

    int m_kill, m_hold, m_cause, m_region, m_count, m_prev;

    mem_guard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .data_addr   (data_addr),
        .r_en        (r_en),
        .w_en        (w_en),
        .irq         (irq),
        .reset       (reset),
        .viol_cause  (viol_cause),
        .viol_region (viol_region),
        .viol_count  (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit tr(input int p);
        return p >= TB && p <= TB + TS - 2;
    endfunction

    function automatic void eval(input int p, input int a, input int r,
                                 input int w, input int ir,
                                 output int c, output int g);
        int c1 = -1;
        int c2 = -1;
        bit ok = 0;
        c = 0;
        g = 0;
        for (int i = 0; i < 5; i++) begin
            if (rs[i] > 0 && a >= rb[i] && a <= rb[i] + rs[i] - 1) begin
                if ((rp[i] & 1) != 0 && c1 < 0) c1 = i;
                if ((rp[i] & 2) != 0 && c2 < 0) c2 = i;
                if ((rp[i] & 4) != 0) ok = 1;
            end
        end
        if (!tr(p) && r != 0 && c1 >= 0) begin
            c = 1; g = c1;
        end else if (!tr(p) && w != 0 && c2 >= 0) begin
            c = 2; g = c2;
        end else if (tr(p) && w != 0 && !ok) begin
            c = 3;
        end
`ifdef MEM_GUARD_ATOMIC_EN
        else if (tr(p) && !tr(m_prev) && p != TB) c = 4;
        else if (tr(m_prev) && !tr(p) && m_prev != TB + TS - 2) c = 5;
        else if (ir != 0 && tr(p)) c = 6;
`endif
    endfunction

    task automatic model_reset();
        m_kill = 0; m_hold = 0; m_cause = 0;
        m_region = 0; m_count = 0; m_prev = RV;
    endtask

    task automatic step(input int p, input int a, input int r,
                        input int w, input int ir);
        int vc, vr;
        pc = 16'(p); data_addr = 16'(a);
        r_en = r[0]; w_en = w[0]; irq = ir[0];
        eval(p, a, r, w, ir, vc, vr);
        @(posedge clk);
        if (m_kill == 0) begin
            if (vc != 0) begin
                m_kill = 1; m_hold = HOLD - 1;
                m_cause = vc; m_region = vr;
                if (m_count < 255) m_count++;
            end
        end else if (m_hold == 0 && p == RV && vc == 0) begin
            m_kill = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        m_prev = p;
        #1;
        chk("reset", reset, m_kill);
        chk("cause", viol_cause, m_cause);
        chk("region", viol_region, m_region);
        chk("count", viol_count, m_count);
    endtask

    task automatic release_kill();
        int n = 0;
        while (m_kill != 0 && n < 50) begin
            step(RV, 0, 0, 0, 0);
            n++;
        end
        chk("release_timeout", m_kill, 0);
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_reset", reset, 0);
        chk("rst_cause", viol_cause, 0);
        chk("rst_region", viol_region, 0);
        chk("rst_count", viol_count, 0);
        model_reset();
        #1 reset_n = 1'b1;
        step(RV, 0, 0, 0, 0);
    endtask

    int hi;

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("por_reset", reset, 0);
        chk("por_cause", viol_cause, 0);
        chk("por_count", viol_count, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step(RV, 0, 0, 0, 0);

        step('h4000, 'hA010, 1, 0, 0);
        chk("rd_reset", reset, 1);
        chk("rd_cause", viol_cause, 1);
        chk("rd_region", viol_region, 0);
        chk("rd_count", viol_count, 1);
        hi = int'(reset);
        step('h4000, 0, 0, 0, 0);
        hi += int'(reset);
        for (int k = 0; k < 20 && reset; k++) begin
            step(RV, 0, 0, 0, 0);
            hi += int'(reset);
        end
        chk("hold_len", hi, 4);
        chk("hold_cause", viol_cause, 1);
        chk("hold_count", viol_count, 1);

        pulse_reset();
        step('hE000, 0, 0, 0, 0);
        step('hE100, 'h8004, 0, 1, 0);
        chk("twr_ok", reset, 0);
        step('hEFFE, 0, 0, 0, 0);
        step(RV, 0, 0, 0, 0);
        step('hE000, 0, 0, 0, 0);
        step('hE100, 'h0200, 0, 1, 0);
        chk("twr_none_cause", viol_cause, 3);
        chk("twr_none_region", viol_region, 0);
        release_kill();
        pulse_reset();
        step('hE000, 0, 0, 0, 0);
        step('hE100, 'hFF00, 0, 1, 0);
        chk("twr_kmem_cause", viol_cause, 3);
        release_kill();

        pulse_reset();
        for (int k = 0; k < 300; k++) begin
            step('h4000, 'hA000, 1, 1, 0);
            if (k == 0) chk("simul_cause", viol_cause, 1);
            release_kill();
        end
        chk("sat_count", viol_count, 255);
        chk("sat_cause", viol_cause, 1);

        step('h4000, 'hA010, 1, 0, 0);
        step('h4000, 0, 0, 0, 0);
        pulse_reset();
        chk("kill_rst_reset", reset, 0);

`ifdef MEM_GUARD_ATOMIC_EN
        pulse_reset();
        step('h4000, 0, 0, 0, 0);
        step('hE002, 0, 0, 0, 0);
        chk("entry_cause", viol_cause, 4);
        pulse_reset();
        step('hE000, 0, 0, 0, 0);
        step('hEFFE, 0, 0, 0, 0);
        step('h4000, 0, 0, 0, 0);
        chk("exit_ok", reset, 0);
        step('hE000, 0, 0, 0, 0);
        step('hE010, 0, 0, 0, 0);
        step('h4000, 0, 0, 0, 0);
        chk("exit_cause", viol_cause, 5);
        pulse_reset();
        step('hE000, 0, 0, 0, 0);
        step('hE010, 0, 0, 0, 1);
        chk("irq_cause", viol_cause, 6);
`endif

        pulse_reset();
        for (int k = 0; k < 600; k++) begin
            int p, a, r, w, ir, sel, ri;
            sel = int'($urandom_range(0, 9));
            if (m_kill != 0 && $urandom_range(0, 9) < 7) p = RV;
            else if (sel < 3) p = RV;
            else if (sel < 5) p = TB + 2 * int'($urandom_range(0, 2047));
            else if (sel == 5) p = TB;
            else if (sel == 6) p = TB + TS - 2;
            else p = int'($urandom_range(0, 'hFFFF));
            ri = int'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 3));
            if (sel == 0) a = rb[ri] - 1 + int'($urandom_range(0, 2));
            else if (sel == 1) a = rb[ri] + rs[ri] - 2 + int'($urandom_range(0, 2));
            else if (sel == 2) a = rb[ri] + int'($urandom_range(0, rs[ri] - 1));
            else a = int'($urandom_range(0, 'hFFFF));
            a = a & 'hFFFF;
            r = ($urandom_range(0, 2) == 0) ? 1 : 0;
            w = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ir = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step(p, a, r, w, ir);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
